// File: rtl/cut_bist_pkg.sv
// Shared constants, state type and LFSR/MISR step functions for the CUT BIST controller.
package cut_bist_pkg;

    localparam int unsigned N_IN  = 14;
    localparam int unsigned N_OUT = 8;

    // x^14+x^5+x^3+x+1 and x^8+x^4+x^3+x^2+1, expressed as feedback tap masks
    localparam logic [N_IN-1:0]  LfsrTaps    = 14'h2015;
    localparam logic [N_OUT-1:0] MisrTaps    = 8'h8E;
    // An all-zero seed would lock the LFSR, so it is swapped for this value
    localparam logic [N_IN-1:0]  ZeroSeedSub = 14'h0001;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } bist_state_e;

    function automatic logic [N_IN-1:0] lfsr_next(input logic [N_IN-1:0] s);
        return {s[N_IN-2:0], ^(s & LfsrTaps)};
    endfunction

    function automatic logic [N_OUT-1:0] misr_next(input logic [N_OUT-1:0] m,
                                                   input logic [N_OUT-1:0] d);
        return {m[N_OUT-2:0], ^(m & MisrTaps)} ^ d;
    endfunction

endpackage

// File: rtl/cut_bist_ctrl_if.sv
// Control/status bundle between a test host and the BIST controller.
interface cut_bist_ctrl_if
    import cut_bist_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic             start;
    logic [CNT_W-1:0] pattern_count;
    logic [N_IN-1:0]  seed;
    logic [N_OUT-1:0] golden_sig;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_OUT-1:0] signature;

    modport master (
        output start, pattern_count, seed, golden_sig,
        input  busy, done, pass, signature
    );

    modport slave (
        input  start, pattern_count, seed, golden_sig,
        output busy, done, pass, signature
    );

endinterface

// File: rtl/cut_bist_misr.sv
// 8-bit multiple-input signature register compacting the CUT outputs.
module cut_bist_misr
    import cut_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    input  logic [N_OUT-1:0] d,
    output logic [N_OUT-1:0] sig
);

    logic [N_OUT-1:0] sig_q, sig_d;

    // Clear has priority so a new run never folds in a stale response
    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = misr_next(sig_q, d);
        end
    end

    // Signature register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/cut_bist_ctrl.sv
// BIST controller: LFSR stimulus into the CUT, MISR compaction of its response,
// golden-signature compare at the end of the run.
module cut_bist_ctrl
    import cut_bist_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    cut_bist_ctrl_if.slave   bus,
    output logic [N_IN-1:0]  pi_o,
    input  logic [N_OUT-1:0] po_i
);

    bist_state_e      state_q, state_d;
    logic [N_IN-1:0]  lfsr_q, lfsr_d;
    logic [N_IN-1:0]  pi_q, pi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_OUT-1:0] golden_q, golden_d;
    logic             pass_q, pass_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cap_q, cap_d;
    logic             start_ok;
    logic             misr_clear;
    logic [N_OUT-1:0] misr_sig;

    // done is registered off StDone, so the cycle it is high is already StIdle;
    // gating on busy/done keeps that cycle deaf to start as well
    assign start_ok = (state_q == StIdle) && bus.start && !busy_q && !done_q;

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        pi_d       = pi_q;
        cnt_d      = cnt_q;
        golden_d   = golden_q;
        pass_d     = pass_q;
        busy_d     = done_q ? 1'b0 : busy_q;
        misr_clear = 1'b0;
        done_d     = (state_q == StDone);
        // A pattern driven this cycle gets its response captured on the following edge
        cap_d      = (state_q == StRun);

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    golden_d   = bus.golden_sig;
                    lfsr_d     = (bus.seed == '0) ? ZeroSeedSub : bus.seed;
                    cnt_d      = bus.pattern_count;
                    misr_clear = 1'b1;
                    pass_d     = 1'b0;
                    state_d    = (bus.pattern_count == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                pi_d   = lfsr_q;
                lfsr_d = lfsr_next(lfsr_q);
                cnt_d  = cnt_q - 1'b1;
                busy_d = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StDone;
            end
            StDone: begin
                pass_d  = (misr_sig == golden_q);
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            lfsr_q   <= '0;
            pi_q     <= '0;
            cnt_q    <= '0;
            golden_q <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cap_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            pi_q     <= pi_d;
            cnt_q    <= cnt_d;
            golden_q <= golden_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cap_q    <= cap_d;
        end
    end

    cut_bist_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (misr_clear),
        .en    (cap_q),
        .d     (po_i),
        .sig   (misr_sig)
    );

    assign pi_o          = pi_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.signature = misr_sig;

endmodule

// File: tb/tb_cut_bist_ctrl.sv
// Scoreboard bench for cut_bist_ctrl with a behavioural CUT.
module tb_cut_bist_ctrl;

    logic        clk;
    logic        rst_n;
    logic [13:0] pi_o;
    logic [7:0]  po_i;
    int          cut_mode;

    int n_cmp;
    int n_err;

    logic [13:0] exp_pi_q[$];
    logic [7:0]  exp_sig_q[$];
    logic        exp_pass_q[$];

    cut_bist_ctrl_if #(.CNT_W(16)) bus ();

    cut_bist_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .pi_o  (pi_o),
        .po_i  (po_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] cut_f(input int mode, input logic [13:0] p);
        case (mode)
            0:       return 8'h00;
            1:       return 8'h01;
            2:       return p[7:0];
            default: return {p[13:10] ^ p[3:0], p[9:6] & p[5:2]};
        endcase
    endfunction

    always_comb po_i = cut_f(cut_mode, pi_o);

    function automatic logic [13:0] m_lfsr(input logic [13:0] s);
        return {s[12:0], s[13] ^ s[4] ^ s[2] ^ s[0]};
    endfunction

    function automatic logic [7:0] m_misr(input logic [7:0] m, input logic [7:0] d);
        return {m[6:0], m[7] ^ m[3] ^ m[2] ^ m[1]} ^ d;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // golden < 0 means "use the model signature as golden"
    task automatic run(input logic [13:0] seed, input int n, input int golden, input int mode,
                       input bit spam);
        logic [13:0] s;
        logic [13:0] first_pat;
        logic [13:0] last_pat;
        logic [7:0]  m;
        logic [7:0]  g;
        int          dc;
        int          dones;
        bit          repeated;

        cut_mode = mode;
        s = (seed == 14'h0) ? 14'h0001 : seed;
        first_pat = s;
        last_pat = 14'h0;
        m = 8'h00;
        for (int k = 0; k < n; k++) begin
            exp_pi_q.push_back(s);
            m = m_misr(m, cut_f(mode, s));
            last_pat = s;
            s = m_lfsr(s);
        end
        g = (golden < 0) ? m : golden[7:0];
        exp_sig_q.push_back(m);
        exp_pass_q.push_back(m == g);
        dc = (n == 0) ? 1 : n + 2;
        dones = 0;
        repeated = 1'b0;

        @(negedge clk);
        bus.seed          = seed;
        bus.pattern_count = n[15:0];
        bus.golden_sig    = g;
        bus.start         = 1'b1;
        @(posedge clk);
        for (int j = 0; j <= dc + 4; j++) begin
            @(negedge clk);
            if (j >= 1 && j <= n) begin
                if (exp_pi_q.size() == 0) check("pi_underrun", 32'd1, 32'd0);
                else check($sformatf("pi[%0d]", j - 1), pi_o, exp_pi_q.pop_front());
                if (j > 1 && pi_o == first_pat) repeated = 1'b1;
            end
            check($sformatf("busy@%0d", j), bus.busy, (n > 0 && j >= 1 && j <= n + 2));
            if (bus.done) dones++;
            if (j == dc) begin
                check("done_cycle", bus.done, 1'b1);
                check("signature", bus.signature, exp_sig_q.pop_front());
                check("pass", bus.pass, exp_pass_q.pop_front());
            end
            bus.start = spam && (j < dc);
        end
        bus.start = 1'b0;
        check("done_count", dones, 1);
        check("sig_hold", bus.signature, m);
        check("pass_hold", bus.pass, (m == g));
        if (n > 0) check("pi_hold", pi_o, last_pat);
        if (n > 2) check("no_short_cycle", repeated, 1'b0);
    endtask

    task automatic abort_run();
        int dones;
        cut_mode = 3;
        dones = 0;
        @(negedge clk);
        bus.seed          = 14'h0155;
        bus.pattern_count = 16'd10;
        bus.golden_sig    = 8'h00;
        bus.start         = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", bus.busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_pi", pi_o, 14'h0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_pass", bus.pass, 1'b0);
        check("abort_sig", bus.signature, 8'h00);
        rst_n = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cut_mode = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.seed = 14'h0;
        bus.pattern_count = 16'h0;
        bus.golden_sig = 8'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pi", pi_o, 14'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_pass", bus.pass, 1'b0);
        check("rst_sig", bus.signature, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(14'h0001, 3, 0, 0, 1'b0);      // 0x0001,0x0003,0x0007; sig 0, done at E0+5
        run(14'h0001, 2, 3, 1, 1'b0);      // sig 0x03, pass
        run(14'h0001, 2, 4, 1, 1'b0);      // sig 0x03, fail
        run(14'h0000, 4, -1, 2, 1'b0);     // zero seed substitute
        run(14'h1234, 0, 0, 2, 1'b0);      // zero patterns, golden 0
        run(14'h1234, 0, 5, 2, 1'b0);      // zero patterns, golden nonzero
        run(14'h2A5C, 10, -1, 3, 1'b1);    // start spammed throughout
        run(14'h2A5C, 10, -1, 3, 1'b0);    // same run again, MISR must restart clean
        abort_run();
        run(14'h0155, 10, -1, 3, 1'b0);
        run(14'h1ACE, 1000, -1, 2, 1'b0);

        check("pi_queue_empty", exp_pi_q.size(), 0);
        check("sig_queue_empty", exp_sig_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
